// File: rtl/ddr_port_pkg.sv
// Shared definitions for the DMA word-port responder: FSM encoding,
// port widths and the stall LFSR constants.
package ddr_port_pkg;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 32;
    localparam int ADDR_W = 32;

    // x^8 + x^6 + x^5 + x^4 + 1, shift-left Fibonacci form (taps on bits 7,5,4,3)
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_DONE,
        ST_RD_DATA,
        ST_RD_DONE
    } state_t;

    // Which direction received the most recent grant
    typedef enum logic {
        RR_WR = 1'b0,
        RR_RD = 1'b1
    } rr_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ddr_port_responder_if.sv
// DMA word-port bundle. master = initiator (DMA side), slave = responder.
interface ddr_port_responder_if;
    import ddr_port_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_ack;
    logic              wr_data_req;
    logic              wr_data_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_req_done;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_data_ready;
    logic              rd_req_done;

    modport master (
        output wr_req, wr_addr, wr_len, wr_data_ready, wr_data,
        output rd_req, rd_addr, rd_len, rd_data_ready,
        input  wr_ack, wr_data_req, wr_req_done,
        input  rd_ack, rd_data, rd_data_valid, rd_req_done
    );

    modport slave (
        input  wr_req, wr_addr, wr_len, wr_data_ready, wr_data,
        input  rd_req, rd_addr, rd_len, rd_data_ready,
        output wr_ack, wr_data_req, wr_req_done,
        output rd_ack, rd_data, rd_data_valid, rd_req_done
    );

endinterface

// File: rtl/ddr_port_ram.sv
// Single-port synchronous word RAM, read-first, one cycle read latency.
module ddr_port_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write on we, always register the addressed word for the read path
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ddr_port_responder.sv
// Responder side of the DMA word port, backed by an on-chip word RAM.
// One request at a time; round-robin between write and read on a tie.
// Optional: define DDR_PORT_RESPONDER_STALL_EN to insert LFSR-driven stall
// cycles on wr_data_req and on read fetches.
module ddr_port_responder
    import ddr_port_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic i_sys_clk,
    input  logic i_reset_n,
    ddr_port_responder_if.slave port
);

    state_t            state_reg, state_next;
    rr_t               rr_last_reg, rr_last_next;
    logic [AW-1:0]     ptr_reg, ptr_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic [LEN_W-1:0]  fetch_left_reg, fetch_left_next;
    logic              wr_ack_reg, wr_ack_next;
    logic              rd_ack_reg, rd_ack_next;

    // Two-entry read output buffer plus a flag for the RAM read in flight
    logic [DATA_W-1:0] obuf_reg [2];
    logic              obuf_head_reg;
    logic [1:0]        obuf_count_reg;
    logic              inflight_reg;

    logic [DATA_W-1:0] ram_rdata;
    logic              stall;
    logic              wr_data_req;
    logic              wr_beat;
    logic              rd_valid;
    logic              pop;
    logic              fetch;
    logic              grant_wr;
    logic              grant_rd;
    logic [2:0]        occupancy;

`ifdef DDR_PORT_RESPONDER_STALL_EN
    logic [7:0] lfsr_reg;

    // Free-running stall pattern generator
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

    // rr_last follows every grant, so a tie goes to whichever side was not served last
    assign grant_wr = port.wr_req && (!port.rd_req || (rr_last_reg == RR_RD));
    assign grant_rd = port.rd_req && !grant_wr;

    assign wr_data_req = (state_reg == ST_WR_DATA) && (cnt_reg != '0) && !stall;
    assign wr_beat     = wr_data_req && port.wr_data_ready;

    assign rd_valid  = (obuf_count_reg != 2'd0);
    assign pop       = rd_valid && port.rd_data_ready;
    // Counting the beat leaving this cycle keeps the pipeline at one word per cycle
    assign occupancy = {1'b0, obuf_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fetch     = (state_reg == ST_RD_DATA) && (fetch_left_reg != '0) &&
                       (occupancy < 3'd2) && !stall;

    assign port.wr_ack        = wr_ack_reg;
    assign port.wr_data_req   = wr_data_req;
    // A zero-length request enters DONE with ack still high; done waits one cycle so they never coincide
    assign port.wr_req_done   = (state_reg == ST_WR_DONE) && !wr_ack_reg;
    assign port.rd_ack        = rd_ack_reg;
    assign port.rd_data_valid = rd_valid;
    assign port.rd_data       = rd_valid ? obuf_reg[obuf_head_reg] : '0;
    assign port.rd_req_done   = (state_reg == ST_RD_DONE) && !rd_ack_reg;

    // Address bits outside the word pointer are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, port.wr_addr[ADDR_W-1:AW+2], port.wr_addr[1:0],
                                port.rd_addr[ADDR_W-1:AW+2], port.rd_addr[1:0]};

    ddr_port_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_ram (
        .clk   (i_sys_clk),
        .we    (wr_beat),
        .addr  (ptr_reg),
        .wdata (port.wr_data),
        .rdata (ram_rdata)
    );

    // Next-state, pointer/counter and ack logic
    always_comb begin
        state_next      = state_reg;
        rr_last_next    = rr_last_reg;
        ptr_next        = ptr_reg;
        cnt_next        = cnt_reg;
        fetch_left_next = fetch_left_reg;
        wr_ack_next     = 1'b0;
        rd_ack_next     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_wr) begin
                    wr_ack_next  = 1'b1;
                    rr_last_next = RR_WR;
                    ptr_next     = port.wr_addr[AW+1:2];
                    cnt_next     = port.wr_len;
                    state_next   = (port.wr_len == '0) ? ST_WR_DONE : ST_WR_DATA;
                end else if (grant_rd) begin
                    rd_ack_next     = 1'b1;
                    rr_last_next    = RR_RD;
                    ptr_next        = port.rd_addr[AW+1:2];
                    cnt_next        = port.rd_len;
                    fetch_left_next = port.rd_len;
                    state_next      = (port.rd_len == '0) ? ST_RD_DONE : ST_RD_DATA;
                end
            end
            ST_WR_DATA: begin
                if (wr_beat) begin
                    ptr_next = ptr_reg + AW'(1);
                    cnt_next = cnt_reg - LEN_W'(1);
                    if (cnt_reg == LEN_W'(1)) begin
                        state_next = ST_WR_DONE;
                    end
                end
            end
            ST_WR_DONE: begin
                if (!wr_ack_reg) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_DATA: begin
                // ptr tracks fetches; cnt tracks beats delivered to the initiator
                if (fetch) begin
                    ptr_next        = ptr_reg + AW'(1);
                    fetch_left_next = fetch_left_reg - LEN_W'(1);
                end
                if (pop) begin
                    cnt_next = cnt_reg - LEN_W'(1);
                    if (cnt_reg == LEN_W'(1)) begin
                        state_next = ST_RD_DONE;
                    end
                end
            end
            ST_RD_DONE: begin
                if (!rd_ack_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM and request-tracking registers
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg      <= ST_IDLE;
            rr_last_reg    <= RR_RD;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            fetch_left_reg <= '0;
            wr_ack_reg     <= 1'b0;
            rd_ack_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_last_reg    <= rr_last_next;
            ptr_reg        <= ptr_next;
            cnt_reg        <= cnt_next;
            fetch_left_reg <= fetch_left_next;
            wr_ack_reg     <= wr_ack_next;
            rd_ack_reg     <= rd_ack_next;
        end
    end

    // Read output buffer: RAM data lands one cycle after its fetch, behind any held word
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 2; i++) begin
                obuf_reg[i] <= '0;
            end
            obuf_head_reg  <= 1'b0;
            obuf_count_reg <= 2'd0;
            inflight_reg   <= 1'b0;
        end else begin
            if (inflight_reg) begin
                obuf_reg[obuf_head_reg ^ obuf_count_reg[0]] <= ram_rdata;
            end
            if (pop) begin
                obuf_head_reg <= ~obuf_head_reg;
            end
            obuf_count_reg <= obuf_count_reg + 2'(inflight_reg) - 2'(pop);
            inflight_reg   <= fetch;
        end
    end

endmodule

// File: tb/tb_ddr_port_responder.sv
// Directed bench for ddr_port_responder (DEPTH=16 so pointer wrap is reachable).
module tb_ddr_port_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ddr_port_responder_if bus();

    ddr_port_responder #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .i_sys_clk (clk),
        .i_reset_n (rst_n),
        .port      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] words [64];

    typedef struct {
        bit               is_wr;
        logic [31:0]      addr;
        int               len;
        bit               toggle;
        logic [7:0][31:0] data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][31:0] w8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input bit toggle);
        int beats = 0, acks = 0, dones = 0, stray = 0;
        int ack_cyc = -1, done_cyc = -1;
        bus.wr_addr = addr;
        bus.wr_len  = len;
        bus.wr_req  = 1'b1;
        for (int cyc = 0; cyc < 600 && dones == 0; cyc++) begin
            @(posedge clk); #1;
            if (bus.wr_ack) begin acks++; ack_cyc = cyc; bus.wr_req = 1'b0; end
            if (bus.wr_req_done) begin dones++; done_cyc = cyc; end
            if (bus.rd_data_valid || bus.rd_ack) stray++;
            bus.wr_data_ready = toggle ? cyc[0] : 1'b1;
            bus.wr_data = (beats < len && beats < 64) ? words[beats] : 32'hDEADBEEF;
            if (bus.wr_data_req && bus.wr_data_ready) beats++;
        end
        bus.wr_req = 1'b0;
        bus.wr_data_ready = 1'b0;
        check("wr_ack_count", acks, 1);
        check("wr_done_count", dones, 1);
        check("wr_beat_count", beats, len);
        check("wr_stray_rd", stray, 0);
`ifndef DDR_PORT_RESPONDER_STALL_EN
        if (!toggle) check("wr_done_latency", done_cyc - ack_cyc, (len == 0) ? 1 : len);
`endif
        $display("txn WR addr=0x%08h len=%0d beats=%0d acks=%0d dones=%0d", addr, len, beats, acks, dones);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input bit toggle);
        int beats = 0, acks = 0, dones = 0, stray = 0;
        int ack_cyc = -1, done_cyc = -1, first_cyc = -1, last_cyc = -1;
        bit held = 1'b0;
        logic [31:0] held_data = '0;
        bus.rd_addr = addr;
        bus.rd_len  = len;
        bus.rd_req  = 1'b1;
        for (int cyc = 0; cyc < 600 && dones == 0; cyc++) begin
            @(posedge clk); #1;
            if (bus.rd_ack) begin acks++; ack_cyc = cyc; bus.rd_req = 1'b0; end
            if (bus.rd_req_done) begin dones++; done_cyc = cyc; end
            if (bus.wr_data_req || bus.wr_ack) stray++;
            if (held) begin
                check("rd_hold_valid", bus.rd_data_valid, 1);
                check("rd_hold_data", bus.rd_data, held_data);
            end
            if (bus.rd_data_valid && first_cyc < 0) first_cyc = cyc;
            bus.rd_data_ready = toggle ? cyc[0] : 1'b1;
            held = bus.rd_data_valid && !bus.rd_data_ready;
            held_data = bus.rd_data;
            if (bus.rd_data_valid && bus.rd_data_ready) begin
                check($sformatf("rd_beat%0d", beats), bus.rd_data,
                      (beats < 64) ? words[beats] : 32'hDEADBEEF);
                beats++;
                last_cyc = cyc;
            end
        end
        bus.rd_req = 1'b0;
        bus.rd_data_ready = 1'b0;
        check("rd_ack_count", acks, 1);
        check("rd_done_count", dones, 1);
        check("rd_beat_count", beats, len);
        check("rd_stray_wr", stray, 0);
`ifndef DDR_PORT_RESPONDER_STALL_EN
        if (len > 0) begin
            check("rd_first_latency", first_cyc - ack_cyc, 2);
            check("rd_done_after_last", done_cyc - last_cyc, 1);
            if (!toggle) check("rd_back_to_back", last_cyc - first_cyc, len - 1);
        end
`endif
        $display("txn RD addr=0x%08h len=%0d beats=%0d acks=%0d dones=%0d", addr, len, beats, acks, dones);
    endtask

    task automatic run_vec(input int i);
        for (int j = 0; j < 8; j++) words[j] = vecs[i].data[j];
        if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].len, vecs[i].toggle);
        else               do_read(vecs[i].addr, vecs[i].len, vecs[i].toggle);
    endtask

    // Both requests raised together with zero length: write wins, read follows,
    // each done exactly one cycle after its ack, no data strobes
    task automatic dual_zero(input int round);
        int wa = 0, ra = 0, wd = 0, rdn = 0, stray = 0;
        int wa_cyc = -1, ra_cyc = -1, wd_cyc = -1, rd_cyc = -1;
        bus.wr_addr = 32'h0; bus.wr_len = 0;
        bus.rd_addr = 32'h0; bus.rd_len = 0;
        bus.wr_req = 1'b1;   bus.rd_req = 1'b1;
        for (int cyc = 0; cyc < 50 && (wd == 0 || rdn == 0); cyc++) begin
            @(posedge clk); #1;
            if (bus.wr_ack) begin wa++; wa_cyc = cyc; bus.wr_req = 1'b0; end
            if (bus.rd_ack) begin ra++; ra_cyc = cyc; bus.rd_req = 1'b0; end
            if (bus.wr_req_done) begin wd++; wd_cyc = cyc; end
            if (bus.rd_req_done) begin rdn++; rd_cyc = cyc; end
            if (bus.wr_data_req || bus.rd_data_valid) stray++;
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        check("tie_wr_ack_count", wa, 1);
        check("tie_rd_ack_count", ra, 1);
        check("tie_wr_done_count", wd, 1);
        check("tie_rd_done_count", rdn, 1);
        check("tie_write_first", (wa_cyc >= 0 && wa_cyc < ra_cyc) ? 1 : 0, 1);
        check("zero_wr_done_delay", wd_cyc - wa_cyc, 1);
        check("zero_rd_done_delay", rd_cyc - ra_cyc, 1);
        check("zero_no_strobes", stray, 0);
        $display("txn TIE round=%0d wr_ack@%0d rd_ack@%0d wr_done@%0d rd_done@%0d",
                 round, wa_cyc, ra_cyc, wd_cyc, rd_cyc);
    endtask

    // Reset asserted while beat 3 of a 10-word read is presented
    task automatic mid_reset();
        int beats = 0, late = 0;
        bus.rd_addr = 32'h10;
        bus.rd_len  = 10;
        bus.rd_data_ready = 1'b1;
        bus.rd_req  = 1'b1;
        for (int cyc = 0; cyc < 100 && beats < 3; cyc++) begin
            @(posedge clk); #1;
            if (bus.rd_ack) bus.rd_req = 1'b0;
            if (bus.rd_data_valid) beats++;
        end
        check("midrst_beats_seen", beats, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl_outputs", {bus.wr_ack, bus.wr_data_req, bus.wr_req_done,
                                      bus.rd_ack, bus.rd_data_valid, bus.rd_req_done}, 0);
        check("midrst_rd_data", bus.rd_data, 0);
        bus.rd_req = 1'b0;
        bus.rd_data_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (bus.rd_req_done || bus.rd_data_valid || bus.rd_ack) late++;
        end
        check("midrst_no_done", late, 0);
        $display("txn RESET during read beat 3, quiet cycles checked, late_events=%0d", late);
        run_vec(6);
    endtask

`ifdef DDR_PORT_RESPONDER_STALL_EN
    logic [7:0] lfsr_model;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_model <= 8'hA5;
        else        lfsr_model <= {lfsr_model[6:0], lfsr_model[7] ^ lfsr_model[5] ^ lfsr_model[4] ^ lfsr_model[3]};
    end

    always @(negedge clk) begin
        if (rst_n && lfsr_model[0]) check("stall_wr_data_req", bus.wr_data_req, 0);
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_len = '0;
        bus.wr_data_ready = 1'b0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
        bus.rd_data_ready = 1'b0;

        vecs[0] = '{1'b1, 32'h100,  4, 1'b0, w8(32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0)};
        vecs[1] = '{1'b0, 32'h100,  4, 1'b0, w8(32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0)};
        vecs[2] = '{1'b1, 32'h10,   8, 1'b1, w8(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                                               32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007)};
        vecs[3] = '{1'b0, 32'h10,   8, 1'b1, w8(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                                               32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007)};
        // word 14 upward wraps to 14,15,0,1
        vecs[4] = '{1'b1, 32'h38,   4, 1'b0, w8(32'hC0, 32'hC1, 32'hC2, 32'hC3, 0, 0, 0, 0)};
        // 0x40 is word 16 -> word 0 after wrap: C2,C3 then the original 0x33,0x44
        vecs[5] = '{1'b0, 32'h40,   4, 1'b0, w8(32'hC2, 32'hC3, 32'h33, 32'h44, 0, 0, 0, 0)};
        vecs[6] = '{1'b0, 32'h38,   2, 1'b0, w8(32'hC0, 32'hC1, 0, 0, 0, 0, 0, 0)};
        // upper and low-order address bits ignored -> word 0
        vecs[7] = '{1'b0, 32'h1003, 1, 1'b0, w8(32'hC2, 0, 0, 0, 0, 0, 0, 0)};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outputs", {bus.wr_ack, bus.wr_data_req, bus.wr_req_done,
                                     bus.rd_ack, bus.rd_data_valid, bus.rd_req_done}, 0);
        check("reset_rd_data", bus.rd_data, 0);
        @(negedge clk) rst_n = 1'b1;

        dual_zero(1);
        dual_zero(2);
        for (int i = 0; i < 8; i++) run_vec(i);
        mid_reset();

`ifdef DDR_PORT_RESPONDER_STALL_EN
        for (int i = 0; i < 64; i++) words[i] = 32'h5A000000 + i;
        do_write(32'h0, 64, 1'b0);
        // 64 words into 16 locations: each location keeps its last pass
        for (int i = 0; i < 64; i++) words[i] = 32'h5A000000 + 48 + (i % 16);
        do_read(32'h0, 64, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
